// File: rtl/video_slot_stabilizer_pkg.sv
// Shared types and slot codes for the video slot stabilizer and its width classifier.
// Pure declarations: no latency, no backpressure.
package video_slot_stabilizer_pkg;

  typedef logic [9:0] width_t;
  typedef logic [8:0] lines_t;
  typedef logic [3:0] slot_t;

  localparam slot_t SLOT_256 = 4'd0;
  localparam slot_t SLOT_360 = 4'd2;
  localparam slot_t SLOT_512 = 4'd4;

  localparam int SLOT_WORD_POS = 13;
  localparam int RGB_W         = 24;

  function automatic logic [RGB_W-1:0] slot_word(input slot_t slot);
    logic [RGB_W-1:0] word;
    word = '0;
    word[SLOT_WORD_POS +: 4] = slot;
    return word;
  endfunction

endpackage

// File: rtl/video_width_classifier.sv
// Maps a measured line width to its 256/360/512 slot class using two thresholds.
// Combinational, zero latency; no backpressure.
module video_width_classifier
  import video_slot_stabilizer_pkg::*;
#(
  parameter int WIDTH_T1 = 280,
  parameter int WIDTH_T2 = 380
) (
  input  width_t width,
  output slot_t  slot
);

  always_comb begin
    if (width < width_t'(WIDTH_T1)) begin
      slot = SLOT_256;
    end else if (width < width_t'(WIDTH_T2)) begin
      slot = SLOT_360;
    end else begin
      slot = SLOT_512;
    end
  end

endmodule

// File: rtl/video_slot_stabilizer.sv
// Measures line/frame geometry and rewrites the post-line slot word with a debounced slot; SLOT_STABILIZE_EN enables frame hysteresis.
// Video path is exactly 1 cycle; streaming sink with no backpressure (downstream must accept every cycle).
module video_slot_stabilizer
  import video_slot_stabilizer_pkg::*;
#(
  parameter int STABLE_FRAMES = 3,
  parameter int WIDTH_T1      = 280,
  parameter int WIDTH_T2      = 380
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        de_in,
  input  logic [23:0] rgb_in,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        de_out,
  output logic [23:0] rgb_out,
  output logic [9:0]  line_width,
  output logic [8:0]  frame_lines,
  output logic        slot_locked
);

  width_t pix_cnt;
  lines_t line_cnt;
  lines_t line_cnt_post;
  logic   armed;
  logic   line_end;
  slot_t  line_class;
  slot_t  word_slot;

  video_width_classifier #(
    .WIDTH_T1 (WIDTH_T1),
    .WIDTH_T2 (WIDTH_T2)
  ) u_classifier (
    .width (pix_cnt),
    .slot  (line_class)
  );

  // de_out is the registered previous de_in; armed blocks a line begun before reset
  assign line_end = de_out && !de_in && armed;

  always_comb begin
    line_cnt_post = line_cnt;
    if (line_end && (line_cnt != '1)) begin
      line_cnt_post = line_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      vsync_out   <= 1'b0;
      hsync_out   <= 1'b0;
      de_out      <= 1'b0;
      rgb_out     <= '0;
      line_width  <= '0;
      frame_lines <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      armed       <= 1'b0;
    end else begin
      vsync_out <= vsync_in;
      hsync_out <= hsync_in;
      de_out    <= de_in;
      rgb_out   <= (de_out && !de_in) ? slot_word(word_slot) : rgb_in;

      if (hsync_in) begin
        pix_cnt <= '0;
        armed   <= 1'b1;
      end else if (de_in && armed && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end

      if (line_end) begin
        line_width <= pix_cnt;
      end

      // An empty frame naturally reports zero lines here
      if (vsync_in) begin
        frame_lines <= line_cnt_post;
        line_cnt    <= '0;
      end else begin
        line_cnt    <= line_cnt_post;
      end
    end
  end

`ifdef SLOT_STABILIZE_EN

  slot_t      frame_class;
  slot_t      frame_class_post;
  slot_t      candidate;
  slot_t      candidate_next;
  logic [3:0] stable_cnt;
  logic [3:0] stable_next;
  slot_t      committed;
  slot_t      committed_next;

  always_comb begin
    frame_class_post = frame_class;
    if (line_end && (line_class > frame_class)) begin
      frame_class_post = line_class;
    end

    candidate_next = candidate;
    stable_next    = stable_cnt;
    if (frame_class_post == candidate) begin
      if (stable_cnt != 4'd15) begin
        stable_next = stable_cnt + 4'd1;
      end
    end else begin
      candidate_next = frame_class_post;
      stable_next    = 4'd1;
    end

    committed_next = committed;
    if (stable_next >= 4'(STABLE_FRAMES)) begin
      committed_next = candidate_next;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      frame_class <= SLOT_256;
      candidate   <= SLOT_256;
      stable_cnt  <= '0;
      committed   <= SLOT_256;
      slot_locked <= 1'b0;
    end else if (vsync_in) begin
      frame_class <= SLOT_256;
      if (line_cnt_post != '0) begin
        candidate   <= candidate_next;
        stable_cnt  <= stable_next;
        committed   <= committed_next;
        slot_locked <= (committed_next == frame_class_post);
      end
    end else begin
      frame_class <= frame_class_post;
    end
  end

  assign word_slot = committed;

`else

  logic [3:0] unused_stable_frames;

  assign unused_stable_frames = 4'(STABLE_FRAMES);
  assign word_slot            = line_class;
  assign slot_locked          = 1'b1;

`endif

endmodule

// File: tb/tb_video_slot_stabilizer.sv
// Directed bench for video_slot_stabilizer; expectations follow SLOT_STABILIZE_EN when defined.
module tb_video_slot_stabilizer;

  logic        clk_vid = 1'b0;
  logic        reset;
  logic        vsync_in;
  logic        hsync_in;
  logic        de_in;
  logic [23:0] rgb_in;
  logic        vsync_out;
  logic        hsync_out;
  logic        de_out;
  logic [23:0] rgb_out;
  logic [9:0]  line_width;
  logic [8:0]  frame_lines;
  logic        slot_locked;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] last_sw;

`ifdef SLOT_STABILIZE_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif

  video_slot_stabilizer #(
    .STABLE_FRAMES (3),
    .WIDTH_T1      (280),
    .WIDTH_T2      (380)
  ) dut (
    .clk_vid     (clk_vid),
    .reset       (reset),
    .vsync_in    (vsync_in),
    .hsync_in    (hsync_in),
    .de_in       (de_in),
    .rgb_in      (rgb_in),
    .vsync_out   (vsync_out),
    .hsync_out   (hsync_out),
    .de_out      (de_out),
    .rgb_out     (rgb_out),
    .line_width  (line_width),
    .frame_lines (frame_lines),
    .slot_locked (slot_locked)
  );

  always #5 clk_vid = ~clk_vid;

  function automatic logic [23:0] slot_w(input logic [3:0] s);
    return {7'b0, s, 13'b0};
  endfunction

  // Drive one input cycle; on return the outputs reflect that cycle (1-cycle latency)
  task automatic cyc(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
    vsync_in = vs;
    hsync_in = hs;
    de_in    = de;
    rgb_in   = rgb;
    @(posedge clk_vid);
    #1;
  endtask

  task automatic send_line(input int w, input logic vs_end);
    cyc(1'b0, 1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < w; i++) cyc(1'b0, 1'b0, 1'b1, 24'(i) ^ 24'h5A5A5A);
    cyc(vs_end, 1'b0, 1'b0, 24'hFFFFFF);
    last_sw = rgb_out;
    cyc(1'b0, 1'b0, 1'b0, 24'h123456);
  endtask

  task automatic vsync_pulse();
    cyc(1'b1, 1'b0, 1'b0, 24'h000000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    cyc(1'b1, 1'b1, 1'b1, 24'hABCDEF);
    n_tests++; if ({vsync_out, hsync_out, de_out} !== 3'b000) begin n_fail++; $display("FAIL reset_sync: got %b required 000", {vsync_out, hsync_out, de_out}); end
    n_tests++; if (rgb_out !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h required 000000", rgb_out); end
    n_tests++; if (line_width !== 10'd0 || frame_lines !== 9'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d required 0/0", line_width, frame_lines); end
    n_tests++; if (slot_locked !== !STAB) begin n_fail++; $display("FAIL reset_locked: got %b required %b", slot_locked, !STAB); end
    reset = 1'b0;
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd0) begin n_fail++; $display("FAIL reset_empty_frame: got %0d required 0", frame_lines); end
  endtask

  task automatic test_passthrough();
    logic [23:0] px [3];
    px[0] = 24'h102030; px[1] = 24'hA0B0C0; px[2] = 24'h0F0F0F;
    cyc(1'b0, 1'b1, 1'b0, 24'h111111);
    n_tests++; if ({vsync_out, hsync_out, de_out} !== 3'b010 || rgb_out !== 24'h111111) begin n_fail++; $display("FAIL pass_hsync: got %b %h required 010 111111", {vsync_out, hsync_out, de_out}, rgb_out); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, px[i]);
      n_tests++; if (de_out !== 1'b1 || rgb_out !== px[i]) begin n_fail++; $display("FAIL pass_pixel%0d: got %b %h required 1 %h", i, de_out, rgb_out, px[i]); end
    end
    cyc(1'b0, 1'b0, 1'b0, 24'hFFFFFF);
    n_tests++; if (de_out !== 1'b0 || rgb_out !== 24'h0) begin n_fail++; $display("FAIL pass_slotword: got %b %h required 0 000000", de_out, rgb_out); end
    n_tests++; if (line_width !== 10'd3) begin n_fail++; $display("FAIL pass_width: got %0d required 3", line_width); end
    cyc(1'b0, 1'b0, 1'b0, 24'h777777);
    n_tests++; if (rgb_out !== 24'h777777) begin n_fail++; $display("FAIL pass_after_slot: got %h required 777777", rgb_out); end
    vsync_pulse();
    n_tests++; if (vsync_out !== 1'b1 || frame_lines !== 9'd1) begin n_fail++; $display("FAIL pass_vsync: got %b %0d required 1 1", vsync_out, frame_lines); end
  endtask

  task automatic test_256();
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 4; l++) send_line(256, 1'b0);
      n_tests++; if (line_width !== 10'd256 || last_sw !== 24'h0) begin n_fail++; $display("FAIL w256_f%0d: got %0d %h required 256 000000", f, line_width, last_sw); end
      vsync_pulse();
      n_tests++; if (frame_lines !== 9'd4 || slot_locked !== 1'b1) begin n_fail++; $display("FAIL w256_frame%0d: got %0d %b required 4 1", f, frame_lines, slot_locked); end
    end
  endtask

  task automatic test_240_lines();
    for (int l = 0; l < 240; l++) send_line(8, 1'b0);
    n_tests++; if (line_width !== 10'd8) begin n_fail++; $display("FAIL lines240_width: got %0d required 8", line_width); end
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd240 || slot_locked !== 1'b1) begin n_fail++; $display("FAIL lines240_frame: got %0d %b required 240 1", frame_lines, slot_locked); end
  endtask

  task automatic test_transient();
    send_line(256, 1'b0);
    send_line(352, 1'b0);
    n_tests++; if (line_width !== 10'd352 || last_sw !== (STAB ? 24'h0 : slot_w(4'd2))) begin n_fail++; $display("FAIL transient_line: got %0d %h required 352 %h", line_width, last_sw, STAB ? 24'h0 : slot_w(4'd2)); end
    send_line(256, 1'b0);
    send_line(256, 1'b0);
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd4 || slot_locked !== !STAB) begin n_fail++; $display("FAIL transient_frame: got %0d %b required 4 %b", frame_lines, slot_locked, !STAB); end
    for (int l = 0; l < 4; l++) send_line(256, 1'b0);
    n_tests++; if (last_sw !== 24'h0) begin n_fail++; $display("FAIL transient_committed: got %h required 000000", last_sw); end
    vsync_pulse();
    n_tests++; if (slot_locked !== 1'b1) begin n_fail++; $display("FAIL transient_relock: got %b required 1", slot_locked); end
  endtask

  task automatic test_switch_512();
    logic [23:0] exp_sw;
    logic        exp_lk;
    for (int f = 0; f < 4; f++) begin
      for (int l = 0; l < 4; l++) send_line(512, 1'b0);
      exp_sw = (!STAB || f == 3) ? slot_w(4'd4) : 24'h0;
      n_tests++; if (line_width !== 10'd512 || last_sw !== exp_sw) begin n_fail++; $display("FAIL switch512_f%0d: got %0d %h required 512 %h", f, line_width, last_sw, exp_sw); end
      vsync_pulse();
      exp_lk = !STAB || f >= 2;
      n_tests++; if (slot_locked !== exp_lk) begin n_fail++; $display("FAIL switch512_lock%0d: got %b required %b", f, slot_locked, exp_lk); end
    end
  endtask

  task automatic test_simultaneous();
    for (int l = 0; l < 3; l++) send_line(512, 1'b0);
    send_line(512, 1'b1);
    n_tests++; if (frame_lines !== 9'd4 || last_sw !== slot_w(4'd4)) begin n_fail++; $display("FAIL simul_frame: got %0d %h required 4 %h", frame_lines, last_sw, slot_w(4'd4)); end
    n_tests++; if (line_width !== 10'd512 || slot_locked !== 1'b1) begin n_fail++; $display("FAIL simul_width: got %0d %b required 512 1", line_width, slot_locked); end
    send_line(512, 1'b0);
    send_line(512, 1'b0);
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd2) begin n_fail++; $display("FAIL simul_next_frame: got %0d required 2", frame_lines); end
  endtask

  task automatic test_empty_frame();
    for (int f = 0; f < 2; f++) begin
      send_line(256, 1'b0);
      send_line(256, 1'b0);
      vsync_pulse();
      n_tests++; if (slot_locked !== !STAB) begin n_fail++; $display("FAIL empty_pre%0d: got %b required %b", f, slot_locked, !STAB); end
    end
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd0 || slot_locked !== !STAB) begin n_fail++; $display("FAIL empty_frame: got %0d %b required 0 %b", frame_lines, slot_locked, !STAB); end
    send_line(256, 1'b0);
    n_tests++; if (last_sw !== (STAB ? slot_w(4'd4) : 24'h0)) begin n_fail++; $display("FAIL empty_hold: got %h required %h", last_sw, STAB ? slot_w(4'd4) : 24'h0); end
    send_line(256, 1'b0);
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd2 || slot_locked !== 1'b1) begin n_fail++; $display("FAIL empty_commit: got %0d %b required 2 1", frame_lines, slot_locked); end
    send_line(256, 1'b0);
    n_tests++; if (last_sw !== 24'h0) begin n_fail++; $display("FAIL empty_slot0: got %h required 000000", last_sw); end
    vsync_pulse();
  endtask

  task automatic test_thresholds();
    int         widths [4];
    logic [3:0] slots  [4];
    widths[0] = 279; widths[1] = 280; widths[2] = 379; widths[3] = 380;
    slots[0]  = 4'd0; slots[1] = 4'd2; slots[2] = 4'd2; slots[3] = 4'd4;
    for (int k = 0; k < 4; k++) begin
      for (int f = 0; f < 3; f++) begin
        send_line(widths[k], 1'b0);
        vsync_pulse();
      end
      n_tests++; if (slot_locked !== 1'b1) begin n_fail++; $display("FAIL thresh_lock_%0d: got %b required 1", widths[k], slot_locked); end
      send_line(widths[k], 1'b0);
      n_tests++; if (last_sw !== slot_w(slots[k])) begin n_fail++; $display("FAIL thresh_slot_%0d: got %h required %h", widths[k], last_sw, slot_w(slots[k])); end
      vsync_pulse();
    end
  endtask

  task automatic test_reset_midline();
    cyc(1'b0, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b1, 24'h333333);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 24'hCCCCCC);
    reset = 1'b0;
    n_tests++; if ({vsync_out, hsync_out, de_out} !== 3'b000 || rgb_out !== 24'h0) begin n_fail++; $display("FAIL midreset_video: got %b %h required 000 000000", {vsync_out, hsync_out, de_out}, rgb_out); end
    n_tests++; if (line_width !== 10'd0 || frame_lines !== 9'd0 || slot_locked !== !STAB) begin n_fail++; $display("FAIL midreset_status: got %0d %0d %b required 0 0 %b", line_width, frame_lines, slot_locked, !STAB); end
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b1, 24'h444444);
    cyc(1'b0, 1'b0, 1'b0, 24'hEEEEEE);
    n_tests++; if (line_width !== 10'd0 || rgb_out !== 24'h0) begin n_fail++; $display("FAIL midreset_partial: got %0d %h required 0 000000", line_width, rgb_out); end
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    send_line(300, 1'b0);
    n_tests++; if (line_width !== 10'd300 || last_sw !== (STAB ? 24'h0 : slot_w(4'd2))) begin n_fail++; $display("FAIL midreset_line: got %0d %h required 300 %h", line_width, last_sw, STAB ? 24'h0 : slot_w(4'd2)); end
    vsync_pulse();
    n_tests++; if (frame_lines !== 9'd1 || slot_locked !== !STAB) begin n_fail++; $display("FAIL midreset_frame: got %0d %b required 1 %b", frame_lines, slot_locked, !STAB); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    de_in    = 1'b0;
    rgb_in   = 24'h0;
    last_sw  = 24'h0;
    test_reset();
    test_passthrough();
    test_256();
    test_240_lines();
    test_transient();
    test_switch_512();
    test_simultaneous();
    test_empty_frame();
    test_thresholds();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
